// File: rtl/mem_bus_arbiter.sv
// Three-way memory bus arbiter: fetch, core data and debug/loader ports.
// Includes a fetch starvation guard and a pause/drain handshake for the MCU.
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fReq,
    input  logic [14:0] i_fAddr,
    input  logic        i_dReq,
    input  logic        i_dWr,
    input  logic [15:0] i_dAddr,
    input  logic [15:0] i_dWData,
    input  logic        i_gReq,
    input  logic        i_gWr,
    input  logic [15:0] i_gAddr,
    input  logic [15:0] i_gWData,
    output logic        o_fGnt,
    output logic        o_dGnt,
    output logic        o_gGnt,
    output logic        o_fValid,
    output logic        o_dValid,
    output logic        o_gValid,
    output logic [15:0] o_rData,
    output logic        o_memEn,
    output logic        o_memWr,
    output logic [15:0] o_memAddr,
    output logic [15:0] o_memWData,
    input  logic [15:0] i_memRData,
    input  logic        i_pauseReq,
    output logic        o_pauseAck
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_PAUSED = 2'd2
    } state_e;

    localparam logic [1:0] OWN_F = 2'd0;
    localparam logic [1:0] OWN_D = 2'd1;
    localparam logic [1:0] OWN_G = 2'd2;
    localparam logic [3:0] SMAX  = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        out_q, out_d;
    logic [1:0]  owner_q, owner_d;
    logic        pause_ack_q, pause_ack_d;

    logic        core_ok;
    logic        starved;
    logic        f_gnt, d_gnt, g_gnt;
    logic        rd_gnt;
    logic [1:0]  rd_owner;

    // Core ports are shut off as soon as a pause is requested.
    assign core_ok = (state_q == S_RUN) && !i_pauseReq;
    assign starved = (starve_q >= SMAX);

    // Grant selection: starved fetch first, then debug > data > fetch.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        g_gnt = 1'b0;
        if (!i_rst) begin
            if (core_ok && i_fReq && starved) f_gnt = 1'b1;
            else if (i_gReq)                  g_gnt = 1'b1;
            else if (core_ok && i_dReq)       d_gnt = 1'b1;
            else if (core_ok && i_fReq)       f_gnt = 1'b1;
        end
    end

    assign o_fGnt = f_gnt;
    assign o_dGnt = d_gnt;
    assign o_gGnt = g_gnt;

    // Memory command mux; fetch is a word-aligned read.
    always_comb begin
        o_memEn    = 1'b0;
        o_memWr    = 1'b0;
        o_memAddr  = 16'h0000;
        o_memWData = 16'h0000;
        rd_gnt     = 1'b0;
        rd_owner   = OWN_F;
        if (f_gnt) begin
            o_memEn   = 1'b1;
            o_memAddr = {i_fAddr, 1'b0};
            rd_gnt    = 1'b1;
            rd_owner  = OWN_F;
        end else if (d_gnt) begin
            o_memEn    = 1'b1;
            o_memWr    = i_dWr;
            o_memAddr  = i_dAddr;
            o_memWData = i_dWData;
            rd_gnt     = !i_dWr;
            rd_owner   = OWN_D;
        end else if (g_gnt) begin
            o_memEn    = 1'b1;
            o_memWr    = i_gWr;
            o_memAddr  = i_gAddr;
            o_memWData = i_gWData;
            rd_gnt     = !i_gWr;
            rd_owner   = OWN_G;
        end
    end

    // Next state, starve counter, outstanding read tracking and ack.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        out_d    = rd_gnt;
        owner_d  = rd_gnt ? rd_owner : owner_q;
        unique case (state_q)
            S_RUN: begin
                if (i_pauseReq) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!i_pauseReq)  state_d = S_RUN;
                else if (!out_q)  state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (!i_pauseReq) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        if (state_q == S_RUN) begin
            if (!i_fReq || f_gnt) starve_d = 4'd0;
            else if (!starved)    starve_d = starve_q + 4'd1;
        end
        pause_ack_d = (state_d == S_PAUSED);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_RUN;
            starve_q    <= 4'd0;
            out_q       <= 1'b0;
            owner_q     <= OWN_F;
            pause_ack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            out_q       <= out_d;
            owner_q     <= owner_d;
            pause_ack_q <= pause_ack_d;
        end
    end

    assign o_fValid   = out_q && (owner_q == OWN_F);
    assign o_dValid   = out_q && (owner_q == OWN_D);
    assign o_gValid   = out_q && (owner_q == OWN_G);
    assign o_rData    = out_q ? i_memRData : 16'h0000;
    assign o_pauseAck = pause_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table plus
// hand-written starvation, pause/unpause and reset sequences.
module tb_mem_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_fReq;
    logic [14:0] i_fAddr;
    logic        i_dReq, i_dWr;
    logic [15:0] i_dAddr, i_dWData;
    logic        i_gReq, i_gWr;
    logic [15:0] i_gAddr, i_gWData;
    logic        o_fGnt, o_dGnt, o_gGnt;
    logic        o_fValid, o_dValid, o_gValid;
    logic [15:0] o_rData;
    logic        o_memEn, o_memWr;
    logic [15:0] o_memAddr, o_memWData;
    logic [15:0] i_memRData;
    logic        i_pauseReq;
    logic        o_pauseAck;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.STARVE_MAX(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_fReq(i_fReq), .i_fAddr(i_fAddr),
        .i_dReq(i_dReq), .i_dWr(i_dWr), .i_dAddr(i_dAddr), .i_dWData(i_dWData),
        .i_gReq(i_gReq), .i_gWr(i_gWr), .i_gAddr(i_gAddr), .i_gWData(i_gWData),
        .o_fGnt(o_fGnt), .o_dGnt(o_dGnt), .o_gGnt(o_gGnt),
        .o_fValid(o_fValid), .o_dValid(o_dValid), .o_gValid(o_gValid),
        .o_rData(o_rData),
        .o_memEn(o_memEn), .o_memWr(o_memWr),
        .o_memAddr(o_memAddr), .o_memWData(o_memWData),
        .i_memRData(i_memRData),
        .i_pauseReq(i_pauseReq), .o_pauseAck(o_pauseAck)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        f_req;
        logic [14:0] f_addr;
        logic        d_req;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        g_req;
        logic        g_wr;
        logic [15:0] g_addr;
        logic [15:0] g_wdata;
        logic [2:0]  e_gnt;
        logic        e_en;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic [2:0]  e_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_reqs();
        i_fReq = 0; i_fAddr = '0;
        i_dReq = 0; i_dWr = 0; i_dAddr = '0; i_dWData = '0;
        i_gReq = 0; i_gWr = 0; i_gAddr = '0; i_gWData = '0;
    endtask

    function automatic logic [2:0] gnts();
        return {o_gGnt, o_dGnt, o_fGnt};
    endfunction

    function automatic logic [2:0] vals();
        return {o_gValid, o_dValid, o_fValid};
    endfunction

    function automatic vec_t mk(
        input logic f, input logic [14:0] fa,
        input logic d, input logic dw, input logic [15:0] da, input logic [15:0] dd,
        input logic g, input logic gw, input logic [15:0] ga, input logic [15:0] gd,
        input logic [2:0] eg, input logic ee, input logic ew,
        input logic [15:0] ea, input logic [15:0] ed, input logic [2:0] ev);
        vec_t v;
        v.f_req = f; v.f_addr = fa;
        v.d_req = d; v.d_wr = dw; v.d_addr = da; v.d_wdata = dd;
        v.g_req = g; v.g_wr = gw; v.g_addr = ga; v.g_wdata = gd;
        v.e_gnt = eg; v.e_en = ee; v.e_wr = ew;
        v.e_addr = ea; v.e_wdata = ed; v.e_valid = ev;
        return v;
    endfunction

    initial begin
        // contention: debug read wins
        vecs[0] = mk(1, 15'h0011, 1, 0, 16'h0200, 16'h1111,
                     1, 0, 16'h0100, 16'h5555,
                     3'b100, 1, 0, 16'h0100, 16'h5555, 3'b100);
        // lone fetch, address shifted
        vecs[1] = mk(1, 15'h1234, 0, 0, 16'h0000, 16'h7777,
                     0, 0, 16'h0000, 16'h0000,
                     3'b001, 1, 0, 16'h2468, 16'h0000, 3'b001);
        // data write, no valid
        vecs[2] = mk(0, 15'h0000, 1, 1, 16'hABCD, 16'h1357,
                     0, 0, 16'h0000, 16'h0000,
                     3'b010, 1, 1, 16'hABCD, 16'h1357, 3'b000);
        // data beats fetch
        vecs[3] = mk(1, 15'h0040, 1, 0, 16'h0300, 16'h0000,
                     0, 0, 16'h0000, 16'h0000,
                     3'b010, 1, 0, 16'h0300, 16'h0000, 3'b010);
        // idle bus
        vecs[4] = mk(0, 15'h0000, 0, 0, 16'hFFFF, 16'hFFFF,
                     0, 0, 16'hFFFF, 16'hFFFF,
                     3'b000, 0, 0, 16'h0000, 16'h0000, 3'b000);
        // debug write beats data
        vecs[5] = mk(0, 15'h0000, 1, 0, 16'h0400, 16'h0000,
                     1, 1, 16'h0500, 16'hA5A5,
                     3'b100, 1, 1, 16'h0500, 16'hA5A5, 3'b000);
        // top fetch address
        vecs[6] = mk(1, 15'h7FFF, 0, 0, 16'h0000, 16'h0000,
                     0, 0, 16'h0000, 16'h0000,
                     3'b001, 1, 0, 16'hFFFE, 16'h0000, 3'b001);

        clear_reqs();
        i_pauseReq = 0;
        i_memRData = 16'hDEAD;
        i_rst = 1;

        // outputs held quiet during reset even with requests
        #2;
        i_fReq = 1; i_dReq = 1; i_gReq = 1;
        @(negedge i_clk);
        chk("rst_gnt", 32'(gnts()), 32'd0);
        chk("rst_en", 32'(o_memEn), 32'd0);
        chk("rst_addr", 32'(o_memAddr), 32'd0);
        chk("rst_valid", 32'(vals()), 32'd0);
        chk("rst_rdata", 32'(o_rData), 32'd0);
        chk("rst_ack", 32'(o_pauseAck), 32'd0);
        clear_reqs();
        @(negedge i_clk);
        i_rst = 0;

        // vector table
        for (int i = 0; i < 7; i++) begin
            step();
            clear_reqs();
            i_fReq = vecs[i].f_req; i_fAddr = vecs[i].f_addr;
            i_dReq = vecs[i].d_req; i_dWr = vecs[i].d_wr;
            i_dAddr = vecs[i].d_addr; i_dWData = vecs[i].d_wdata;
            i_gReq = vecs[i].g_req; i_gWr = vecs[i].g_wr;
            i_gAddr = vecs[i].g_addr; i_gWData = vecs[i].g_wdata;
            @(negedge i_clk);
            chk($sformatf("v%0d_gnt", i), 32'(gnts()), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_en", i), 32'(o_memEn), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_wr", i), 32'(o_memWr), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_addr", i), 32'(o_memAddr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_wdata", i), 32'(o_memWData), 32'(vecs[i].e_wdata));
            step();
            clear_reqs();
            i_memRData = 16'hC000 + 16'(i);
            @(negedge i_clk);
            chk($sformatf("v%0d_valid", i), 32'(vals()), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_rdata", i), 32'(o_rData),
                (vecs[i].e_valid != 3'b000) ? 32'(16'hC000 + 16'(i)) : 32'd0);
        end

        // starvation: data wins 4 cycles, fetch on 5th, then data again
        step();
        clear_reqs();
        i_dReq = 1; i_fReq = 1; i_dAddr = 16'h0600; i_fAddr = 15'h0100;
        i_memRData = 16'h3C3C;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            chk($sformatf("starve_c%0d_gnt", c), 32'(gnts()),
                (c == 4) ? 32'd1 : 32'd2);
            if (c == 4)
                chk("starve_faddr", 32'(o_memAddr), 32'h0200);
            if (c > 0) begin
                chk($sformatf("starve_c%0d_val", c), 32'(vals()),
                    (c == 5) ? 32'd1 : 32'd2);
                chk($sformatf("starve_c%0d_rd", c), 32'(o_rData), 32'h3C3C);
            end
            step();
        end
        clear_reqs();
        step();

        // pause: fetch read in N, pause from N+1
        i_fReq = 1; i_fAddr = 15'h0008;
        @(negedge i_clk);
        chk("pz_n_fgnt", 32'(o_fGnt), 32'd1);
        step();
        i_pauseReq = 1; i_dReq = 1; i_memRData = 16'hBEEF;
        @(negedge i_clk);
        chk("pz_n1_gnt", 32'(gnts()), 32'd0);
        chk("pz_n1_fval", 32'(o_fValid), 32'd1);
        chk("pz_n1_rdata", 32'(o_rData), 32'hBEEF);
        chk("pz_n1_ack", 32'(o_pauseAck), 32'd0);
        step();
        @(negedge i_clk);
        chk("pz_n2_gnt", 32'(gnts()), 32'd0);
        chk("pz_n2_val", 32'(vals()), 32'd0);
        chk("pz_n2_ack", 32'(o_pauseAck), 32'd0);
        step();
        i_gReq = 1; i_gWr = 1; i_gAddr = 16'h0700; i_gWData = 16'h0F0F;
        @(negedge i_clk);
        chk("pz_n3_ack", 32'(o_pauseAck), 32'd1);
        chk("pz_n3_gnt", 32'(gnts()), 32'd4);
        chk("pz_n3_wr", 32'(o_memWr), 32'd1);
        chk("pz_n3_addr", 32'(o_memAddr), 32'h0700);

        // unpause: no core grant in the dropping cycle, fetch after
        step();
        i_gReq = 0; i_dReq = 0; i_pauseReq = 0;
        @(negedge i_clk);
        chk("up_m_ack", 32'(o_pauseAck), 32'd1);
        chk("up_m_gnt", 32'(gnts()), 32'd0);
        step();
        @(negedge i_clk);
        chk("up_m1_ack", 32'(o_pauseAck), 32'd0);
        chk("up_m1_fgnt", 32'(gnts()), 32'd1);
        step();
        clear_reqs();
        step();

        // reset right after a data read grant drops the valid
        i_dReq = 1; i_dAddr = 16'h0900;
        @(negedge i_clk);
        chk("rr_dgnt", 32'(o_dGnt), 32'd1);
        step();
        i_rst = 1;
        i_gReq = 1; i_fReq = 1;
        i_memRData = 16'h9999;
        #1;
        chk("rr_dval", 32'(o_dValid), 32'd0);
        chk("rr_gnt", 32'(gnts()), 32'd0);
        chk("rr_en", 32'(o_memEn), 32'd0);
        chk("rr_rdata", 32'(o_rData), 32'd0);
        chk("rr_ack", 32'(o_pauseAck), 32'd0);
        clear_reqs();
        @(negedge i_clk);
        i_rst = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge i_clk);
            chk($sformatf("rr_post%0d_val", c), 32'(vals()), 32'd0);
            chk($sformatf("rr_post%0d_rd", c), 32'(o_rData), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
